// File: rtl/axi_arb_pkg.sv
// Shared definitions for the AXI-lite N-to-1 arbiter family.
//   - arbitration policy selectors
//   - arbiter state encoding
//   - AXI response codes
package axi_arb_pkg;

  localparam int unsigned ARB_MODE_FIXED = 0;
  localparam int unsigned ARB_MODE_RR    = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_TIMEOUT = 2'd2
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection.
//   req_i    : request vector, one bit per master
//   rr_ptr_i : round-robin start index (ignored in fixed-priority mode)
//   grant_o  : one-hot winner, all zero when no request
//   idx_o    : binary index of the winner
//   valid_o  : at least one request present
module arb_pick
  import axi_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ARB_MODE    = ARB_MODE_FIXED,
  parameter int unsigned IDX_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [IDX_W-1:0]       rr_ptr_i,
  output logic [NUM_MASTERS-1:0] grant_o,
  output logic [IDX_W-1:0]       idx_o,
  output logic                   valid_o
);

  logic [IDX_W-1:0] base;

  // Fixed priority is a circular scan that always starts at index 0.
  assign base = (ARB_MODE == ARB_MODE_RR) ? rr_ptr_i : '0;

  always_comb begin : pick
    int unsigned      j;
    logic [IDX_W-1:0] jw;
    logic             found;
    j       = 0;
    jw      = '0;
    found   = 1'b0;
    grant_o = '0;
    idx_o   = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      j  = (32'(base) + k) % NUM_MASTERS;
      jw = IDX_W'(j);
      if (!found && req_i[jw]) begin
        found       = 1'b1;
        grant_o[jw] = 1'b1;
        idx_o       = jw;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/axi_lite_nto1_arbiter.sv
// N-master to 1-slave AXI-lite arbiter.
//   clk, rst            : clock, synchronous active-high reset
//   m_req               : per-master request, held until its response completes
//   m_ar*/m_aw*/m_w*    : packed per-master request channels (slice i = master i)
//   m_r*/m_b*           : packed per-master response channels
//   s_*                 : single slave port, driven only while a grant is held
//   grant               : one-hot current owner (zero in IDLE)
//   busy                : high in GRANT or TIMEOUT
// A grant ends only on a completed R or B handshake; an owner whose grant
// stays open for TIMEOUT_CYCLES is completed locally with SLVERR.
module axi_lite_nto1_arbiter
  import axi_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned ARB_MODE       = ARB_MODE_FIXED,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_MASTERS-1:0]                m_req,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_araddr,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_awaddr,
  input  logic [NUM_MASTERS-1:0]                m_arvalid,
  input  logic [NUM_MASTERS-1:0]                m_awvalid,
  input  logic [NUM_MASTERS-1:0]                m_wvalid,
  input  logic [NUM_MASTERS-1:0]                m_rready,
  input  logic [NUM_MASTERS-1:0]                m_bready,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_wdata,
  input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0] m_wstrb,
  output logic [NUM_MASTERS-1:0]                m_arready,
  output logic [NUM_MASTERS-1:0]                m_awready,
  output logic [NUM_MASTERS-1:0]                m_wready,
  output logic [NUM_MASTERS-1:0]                m_rvalid,
  output logic [NUM_MASTERS-1:0]                m_bvalid,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_rdata,
  output logic [NUM_MASTERS*2-1:0]              m_rresp,
  output logic [NUM_MASTERS*2-1:0]              m_bresp,
  output logic [ADDR_WIDTH-1:0]                 s_araddr,
  output logic [ADDR_WIDTH-1:0]                 s_awaddr,
  output logic                                  s_arvalid,
  output logic                                  s_awvalid,
  output logic                                  s_wvalid,
  output logic                                  s_rready,
  output logic                                  s_bready,
  output logic [DATA_WIDTH-1:0]                 s_wdata,
  output logic [DATA_WIDTH/8-1:0]               s_wstrb,
  input  logic                                  s_arready,
  input  logic                                  s_awready,
  input  logic                                  s_wready,
  input  logic                                  s_rvalid,
  input  logic                                  s_bvalid,
  input  logic [DATA_WIDTH-1:0]                 s_rdata,
  input  logic [1:0]                            s_rresp,
  input  logic [1:0]                            s_bresp,
  output logic [NUM_MASTERS-1:0]                grant,
  output logic                                  busy
);

  localparam int unsigned IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned SW = DATA_WIDTH / 8;
  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  arb_state_e             state_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [IW-1:0]          idx_q;
  logic [IW-1:0]          rr_ptr_q;
  logic [CW-1:0]          cnt_q;
  logic                   busy_q;

  logic                   release_w;
  logic                   tmo_hit;
  logic [IW-1:0]          ptr_inc;
  logic [NUM_MASTERS-1:0] pick_req;
  logic [IW-1:0]          pick_ptr;
  logic [NUM_MASTERS-1:0] pick_grant;
  logic [IW-1:0]          pick_idx;
  logic                   pick_valid;

  assign grant = grant_q;
  assign busy  = busy_q;

  assign ptr_inc = (idx_q == IW'(NUM_MASTERS - 1)) ? '0 : idx_q + 1'b1;

  // Re-arbitration in the release cycle starts from the pointer value being
  // written this cycle, so back-to-back grants need no idle cycle.
  always_comb begin
    pick_req = m_req;
    pick_ptr = rr_ptr_q;
    if (state_q != ST_IDLE) begin
      pick_ptr = ptr_inc;
      if (ARB_MODE == ARB_MODE_RR) pick_req = m_req & ~grant_q;
    end
  end

  arb_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .ARB_MODE    (ARB_MODE),
    .IDX_W       (IW)
  ) u_pick (
    .req_i    (pick_req),
    .rr_ptr_i (pick_ptr),
    .grant_o  (pick_grant),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

  // In TIMEOUT the arbiter itself drives valid=1, so the owner's ready alone
  // completes the handshake.
  always_comb begin
    release_w = 1'b0;
    if (state_q == ST_GRANT)
      release_w = (s_rvalid & m_rready[idx_q]) | (s_bvalid & m_bready[idx_q]);
    else if (state_q == ST_TIMEOUT)
      release_w = m_rready[idx_q] | m_bready[idx_q];
  end

  assign tmo_hit = (TIMEOUT_CYCLES != 0) && ((cnt_q + 1'b1) == CW'(TIMEOUT_CYCLES));

  always_comb begin
    s_araddr  = '0;
    s_awaddr  = '0;
    s_arvalid = 1'b0;
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    s_rready  = 1'b0;
    s_bready  = 1'b0;
    s_wdata   = '0;
    s_wstrb   = '0;
    m_arready = '0;
    m_awready = '0;
    m_wready  = '0;
    m_rvalid  = '0;
    m_bvalid  = '0;
    m_rdata   = '0;
    m_rresp   = '0;
    m_bresp   = '0;
    if (state_q == ST_GRANT) begin
      s_araddr  = m_araddr[idx_q*ADDR_WIDTH +: ADDR_WIDTH];
      s_awaddr  = m_awaddr[idx_q*ADDR_WIDTH +: ADDR_WIDTH];
      s_arvalid = m_arvalid[idx_q];
      s_awvalid = m_awvalid[idx_q];
      s_wvalid  = m_wvalid[idx_q];
      s_rready  = m_rready[idx_q];
      s_bready  = m_bready[idx_q];
      s_wdata   = m_wdata[idx_q*DATA_WIDTH +: DATA_WIDTH];
      s_wstrb   = m_wstrb[idx_q*SW +: SW];
      m_arready[idx_q]                    = s_arready;
      m_awready[idx_q]                    = s_awready;
      m_wready[idx_q]                     = s_wready;
      m_rvalid[idx_q]                     = s_rvalid;
      m_bvalid[idx_q]                     = s_bvalid;
      m_rdata[idx_q*DATA_WIDTH +: DATA_WIDTH] = s_rdata;
      m_rresp[idx_q*2 +: 2]               = s_rresp;
      m_bresp[idx_q*2 +: 2]               = s_bresp;
    end else if (state_q == ST_TIMEOUT) begin
      m_rvalid[idx_q]       = 1'b1;
      m_bvalid[idx_q]       = 1'b1;
      m_rresp[idx_q*2 +: 2] = RESP_SLVERR;
      m_bresp[idx_q*2 +: 2] = RESP_SLVERR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      idx_q    <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            state_q <= ST_GRANT;
            grant_q <= pick_grant;
            idx_q   <= pick_idx;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_GRANT, ST_TIMEOUT: begin
          // A real response in the expiry cycle takes precedence over timeout.
          if (release_w) begin
            rr_ptr_q <= ptr_inc;
            cnt_q    <= '0;
            if (pick_valid) begin
              state_q <= ST_GRANT;
              grant_q <= pick_grant;
              idx_q   <= pick_idx;
              busy_q  <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
              grant_q <= '0;
              busy_q  <= 1'b0;
            end
          end else if (state_q == ST_GRANT) begin
            if (tmo_hit) state_q <= ST_TIMEOUT;
            else         cnt_q   <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/axi_lite_nto1_arbiter.md
Name: axi_lite_nto1_arbiter

Overview:
- Parametrised N-master to 1-slave AXI-lite arbiter between CPU memory clients (IFU, LSU, future DMA/debug) and the single memory/peripheral bus.
- Generalises the fixed 2-master IFU/LSU arbiter with these additions:
  - configurable master count;
  - selectable fixed-priority or round-robin policy;
  - grant release only on a completed response handshake;
  - a per-grant timeout that returns an error response.

Parameters:
NUM_MASTERS, 2, number of requesting masters (2..8); index 0 is highest priority in fixed mode
DATA_WIDTH, 32, data bus width
ADDR_WIDTH, 32, address bus width
ARB_MODE, 0, 0 = fixed priority, 1 = round robin
TIMEOUT_CYCLES, 1023, cycles a grant may stay open before forced error completion; 0 disables the timeout

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
m_req  in  NUM_MASTERS  per-master transaction request, held until the response handshake completes
m_araddr/m_awaddr  in  NUM_MASTERS*ADDR_WIDTH  packed per-master addresses; master i occupies slice i
m_arvalid/m_awvalid/m_wvalid/m_rready/m_bready  in  NUM_MASTERS  per-master handshake inputs
m_wdata  in  NUM_MASTERS*DATA_WIDTH  packed write data
m_wstrb  in  NUM_MASTERS*(DATA_WIDTH/8)  packed write strobes
m_arready/m_awready/m_wready/m_rvalid/m_bvalid  out  NUM_MASTERS  per-master handshake outputs
m_rdata  out  NUM_MASTERS*DATA_WIDTH  packed read data
m_rresp/m_bresp  out  NUM_MASTERS*2  packed responses
s_araddr/s_awaddr  out  ADDR_WIDTH  slave addresses
s_arvalid/s_awvalid/s_wvalid/s_rready/s_bready  out  1  slave handshake outputs
s_wdata  out  DATA_WIDTH  write data to slave
s_wstrb  out  DATA_WIDTH/8  write strobes to slave
s_arready/s_awready/s_wready/s_rvalid/s_bvalid  in  1  slave handshake inputs
s_rdata  in  DATA_WIDTH  read data from slave
s_rresp/s_bresp  in  2  slave responses
grant  out  NUM_MASTERS  one-hot current owner; all zero in IDLE
busy  out  1  high while in GRANT or TIMEOUT

Behaviour:
- State machine, states IDLE, GRANT, TIMEOUT.
- Reset:
  - state = IDLE, grant = 0, busy = 0;
  - round-robin pointer = 0, timeout counter = 0;
  - every output is 0.
- IDLE:
  - if any m_req is set, pick the winner, register a one-hot grant and go to GRANT next cycle.
  - Fixed mode: the lowest set index wins.
  - Round-robin mode: the first set index at or after rr_ptr (circular) wins.
- GRANT:
  - The granted master's signals pass combinationally to/from the slave.
  - All non-granted masters see ready/valid/rdata/resp = 0.
  - The s_* outputs are 0 when no grant is held.
- Release: the cycle of (s_rvalid & s_rready) or (s_bvalid & s_bready) ends the grant. A bare valid without ready never releases.
- At release:
  - round-robin pointer becomes winner+1, wrapping modulo NUM_MASTERS;
  - arbitration restarts in the same cycle, excluding the just-released master only in RR mode;
  - next cycle enters GRANT with the new owner, or IDLE if no m_req is set. Back-to-back grants cost zero idle cycles.
- New requests arriving mid-GRANT wait; there is no preemption.
- Timeout:
  - counter clears on grant and increments each GRANT cycle;
  - on reaching TIMEOUT_CYCLES, go to TIMEOUT;
  - s_* valid/ready are forced to 0;
  - the owner gets m_rvalid and m_bvalid = 1 with resp = 2'b10 (SLVERR);
  - TIMEOUT ends on the owner's rready or bready handshake, then behaves as a release.
- Simultaneous timeout expiry and slave response handshake: the real response wins and no TIMEOUT is entered.
- Reset asserted mid-transaction: immediate return to the reset state next edge. Slave-side recovery is the system's responsibility.

Decomposition:
- Shared package axi_arb_pkg holds:
  - ARB_MODE_FIXED/ARB_MODE_RR constants;
  - state encoding (IDLE/GRANT/TIMEOUT);
  - AXI resp codes OKAY=2'b00, SLVERR=2'b10.
- One sub-module, arb_pick:
  - combinational winner selection from req vector, rr_ptr and mode;
  - output is a one-hot grant plus binary index.
  - It is reused by future interconnects.

Test Plan:
- Fixed mode, NUM_MASTERS=2, m_req=2'b11 held → grant=01 for each transaction while master 0 keeps requesting; master 1 starves by design.
- RR mode, NUM_MASTERS=4, m_req=4'b1111 continuously, slave responds in 1 cycle → grant sequence 0001,0010,0100,1000,0001 with no IDLE cycles.
- Read from master 1 at araddr 0x8000_0010, slave returns rdata 0xDEADBEEF OKAY → m_rdata slice 1 = 0xDEADBEEF, slice 0 = 0; s_rvalid held 3 cycles with m_rready=0 keeps the grant until rready=1.
- Write from master 0, wdata 0x1234_5678, wstrb 4'b0011 → s_wdata/s_wstrb match; grant releases on bvalid&bready; bresp = OKAY.
- TIMEOUT_CYCLES=8, slave never asserts arready → after 8 GRANT cycles, owner sees rvalid=1, rresp=2'b10; releases on rready.
- rst=1 asserted mid-GRANT → next edge grant=0, busy=0, all s_* outputs=0; RR pointer back to 0.
